dmem_arbiter: RTL and testbench

// Shares the single-port data memory between two requesters. Port C is the

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port (core C / auxiliary A) arbiter for a single-port data memory
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_err,
  output logic              c_stall,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_rd_en,
  output logic              m_wr_en,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              gnt_id
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_TURN  = 3'd4;

  localparam int CNT_W = $clog2(READ_LAT + 1);

  logic [2:0]        state;
  logic              last_gnt;
  logic              cur_read;
  logic [CNT_W-1:0]  wait_cnt;

  logic              pick_a;
  logic              sel_we;
  logic              sel_mis;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Winner selection: on a tie, round-robin favours the port not served last; fixed mode always favours C
  always_comb begin
    pick_a = 1'b0;
    if (c_req && a_req) begin
      pick_a = (ARB_MODE == 0) ? ~last_gnt : 1'b0;
    end else begin
      pick_a = a_req;
    end
    sel_we    = pick_a ? a_we    : c_we;
    sel_addr  = pick_a ? a_addr  : c_addr;
    sel_wdata = pick_a ? a_wdata : c_wdata;
    sel_mis   = |sel_addr[1:0];
  end

  assign c_stall = c_req & ~c_ack;
  assign busy    = (state != S_IDLE);

  // Transaction FSM; strobes, acks and error flags are single-cycle pulses set one edge ahead
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      last_gnt <= 1'b1;
      gnt_id   <= 1'b0;
      cur_read <= 1'b0;
      wait_cnt <= '0;
      c_ack    <= 1'b0;
      a_ack    <= 1'b0;
      c_err    <= 1'b0;
      a_err    <= 1'b0;
      c_rdata  <= '0;
      a_rdata  <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_rd_en  <= 1'b0;
      m_wr_en  <= 1'b0;
    end else begin
      c_ack   <= 1'b0;
      a_ack   <= 1'b0;
      c_err   <= 1'b0;
      a_err   <= 1'b0;
      m_rd_en <= 1'b0;
      m_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (c_req || a_req) begin
            gnt_id   <= pick_a;
            last_gnt <= pick_a;
            m_addr   <= sel_addr;
            m_wdata  <= sel_wdata;
            cur_read <= ~sel_we & ~sel_mis;
            state    <= S_ISSUE;
            if (sel_mis) begin
              // Misaligned: complete immediately with an error, memory untouched
              if (pick_a) begin
                a_ack   <= 1'b1;
                a_err   <= 1'b1;
                a_rdata <= '0;
              end else begin
                c_ack   <= 1'b1;
                c_err   <= 1'b1;
                c_rdata <= '0;
              end
            end else if (sel_we) begin
              m_wr_en <= 1'b1;
              if (pick_a) a_ack <= 1'b1;
              else        c_ack <= 1'b1;
            end else begin
              m_rd_en <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (cur_read) begin
            wait_cnt <= CNT_W'(READ_LAT - 1);
            state    <= S_WAIT;
          end else begin
            state <= S_TURN;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_RESP;
            if (gnt_id) begin
              a_ack   <= 1'b1;
              a_rdata <= m_rdata;
            end else begin
              c_ack   <= 1'b1;
              c_rdata <= m_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_RESP: state <= S_TURN;
        // Dead cycle so a registered master can drop req after its ack
        S_TURN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized check of two arbiter configurations against a transaction-level model
module tb_dmem_arbiter;

  localparam int RL0 = 1;
  localparam int RL1 = 3;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst;

  logic        c_req [2], c_we [2], a_req [2], a_we [2];
  logic [31:0] c_addr [2], c_wdata [2], a_addr [2], a_wdata [2], m_rdata [2];
  logic        c_ack [2], c_err [2], c_stall [2], a_ack [2], a_err [2];
  logic        m_rd_en [2], m_wr_en [2], busy [2], gnt_id [2];
  logic [31:0] c_rdata [2], a_rdata [2], m_addr [2], m_wdata [2];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL0), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
    .c_ack(c_ack[0]), .c_rdata(c_rdata[0]), .c_err(c_err[0]), .c_stall(c_stall[0]),
    .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
    .a_ack(a_ack[0]), .a_rdata(a_rdata[0]), .a_err(a_err[0]),
    .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_rd_en(m_rd_en[0]), .m_wr_en(m_wr_en[0]),
    .m_rdata(m_rdata[0]), .busy(busy[0]), .gnt_id(gnt_id[0])
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL1), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst(rst),
    .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
    .c_ack(c_ack[1]), .c_rdata(c_rdata[1]), .c_err(c_err[1]), .c_stall(c_stall[1]),
    .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
    .a_ack(a_ack[1]), .a_rdata(a_rdata[1]), .a_err(a_err[1]),
    .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_rd_en(m_rd_en[1]), .m_wr_en(m_wr_en[1]),
    .m_rdata(m_rdata[1]), .busy(busy[1]), .gnt_id(gnt_id[1])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int rl_of(input int k);
    return (k == 0) ? RL0 : RL1;
  endfunction

  function automatic bit fixed_of(input int k);
    return (k == 1);
  endfunction

  // Transaction-level model state, one set per configuration
  bit          active [2];
  int          t_issue [2], t_ack [2], next_free [2];
  bit          t_port [2], t_we [2], t_mis [2];
  logic [31:0] t_addr [2], t_wdata [2], t_rdata [2];
  bit          last_gnt [2];
  logic [31:0] e_maddr [2], e_mwdata [2];
  bit          e_gnt [2];
  logic [31:0] ref_mem [2][16];
  logic [31:0] dut_mem [2][16];
  int          rd_due [2];
  logic [3:0]  rd_idx [2];
  bit          pend [2][2];
  bit          drop [2][2];
  int          n_acks [2];
  int          n_err_acks;
  int          n_resets;
  bit          rst_prev;

  initial begin
    rst = 1'b1;
    rst_prev = 1'b1;
    n_err_acks = 0;
    n_resets = 0;
    for (int k = 0; k < 2; k++) begin
      c_req[k] = 1'b0; c_we[k] = 1'b0; c_addr[k] = '0; c_wdata[k] = '0;
      a_req[k] = 1'b0; a_we[k] = 1'b0; a_addr[k] = '0; a_wdata[k] = '0;
      m_rdata[k] = '0;
      active[k] = 1'b0; next_free[k] = 0; last_gnt[k] = 1'b1;
      t_issue[k] = -1; t_ack[k] = -1;
      e_maddr[k] = '0; e_mwdata[k] = '0; e_gnt[k] = 1'b0;
      rd_due[k] = -1; rd_idx[k] = '0; n_acks[k] = 0;
      for (int p = 0; p < 2; p++) begin
        pend[k][p] = 1'b0;
        drop[k][p] = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
        ref_mem[k][i] = 32'hA500_0000 + 32'(i);
        dut_mem[k][i] = 32'hA500_0000 + 32'(i);
      end
    end

    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      // Compare this cycle's outputs with the model
      for (int k = 0; k < 2; k++) begin
        bit issue_now, ack_now, exp_busy;
        if (rst_prev) begin
          active[k]    = 1'b0;
          next_free[k] = n;
          last_gnt[k]  = 1'b1;
          e_maddr[k]   = '0;
          e_mwdata[k]  = '0;
          e_gnt[k]     = 1'b0;
          check($sformatf("%0d:rst_c_rdata", k), c_rdata[k], 32'h0);
          check($sformatf("%0d:rst_a_rdata", k), a_rdata[k], 32'h0);
          check($sformatf("%0d:rst_c_err", k), 32'(c_err[k]), 32'h0);
          check($sformatf("%0d:rst_a_err", k), 32'(a_err[k]), 32'h0);
        end
        issue_now = active[k] && (n == t_issue[k]);
        ack_now   = active[k] && (n == t_ack[k]);
        exp_busy  = active[k] && (n >= t_issue[k]) && (n < next_free[k]);
        if (issue_now) begin
          e_maddr[k]  = t_addr[k];
          e_mwdata[k] = t_wdata[k];
          e_gnt[k]    = t_port[k];
        end
        check($sformatf("%0d:m_wr_en", k), 32'(m_wr_en[k]), 32'(issue_now && t_we[k] && !t_mis[k]));
        check($sformatf("%0d:m_rd_en", k), 32'(m_rd_en[k]), 32'(issue_now && !t_we[k] && !t_mis[k]));
        check($sformatf("%0d:c_ack", k), 32'(c_ack[k]), 32'(ack_now && !t_port[k]));
        check($sformatf("%0d:a_ack", k), 32'(a_ack[k]), 32'(ack_now && t_port[k]));
        check($sformatf("%0d:busy", k), 32'(busy[k]), 32'(exp_busy));
        check($sformatf("%0d:gnt_id", k), 32'(gnt_id[k]), 32'(e_gnt[k]));
        check($sformatf("%0d:m_addr", k), m_addr[k], e_maddr[k]);
        check($sformatf("%0d:m_wdata", k), m_wdata[k], e_mwdata[k]);
        if (ack_now) begin
          n_acks[k]++;
          if (t_mis[k]) n_err_acks++;
          if (t_port[k]) begin
            check($sformatf("%0d:a_err", k), 32'(a_err[k]), 32'(t_mis[k]));
            if (!t_we[k] || t_mis[k]) check($sformatf("%0d:a_rdata", k), a_rdata[k], t_rdata[k]);
          end else begin
            check($sformatf("%0d:c_err", k), 32'(c_err[k]), 32'(t_mis[k]));
            if (!t_we[k] || t_mis[k]) check($sformatf("%0d:c_rdata", k), c_rdata[k], t_rdata[k]);
          end
        end
      end

      rst = (n < 2) || ($urandom_range(0, 199) == 0);
      if (rst && n >= 2) n_resets++;

      for (int k = 0; k < 2; k++) begin
        // Memory behind the DUT: writes land immediately, reads return READ_LAT cycles after the strobe
        if (m_wr_en[k]) dut_mem[k][m_addr[k][5:2]] = m_wdata[k];
        m_rdata[k] = (n == rd_due[k]) ? dut_mem[k][rd_idx[k]] : $urandom;
        if (m_rd_en[k]) begin
          rd_due[k] = n + rl_of(k);
          rd_idx[k] = m_addr[k][5:2];
        end

        // Registered masters: hold req until ack, drop it the cycle after, then maybe issue again
        for (int p = 0; p < 2; p++) begin
          bit          nwe;
          logic [31:0] naddr, nwdata;
          if (drop[k][p]) begin
            pend[k][p] = 1'b0;
            drop[k][p] = 1'b0;
          end
          if (!pend[k][p] && $urandom_range(0, 3) != 0) begin
            pend[k][p] = 1'b1;
            nwe    = 1'($urandom_range(0, 1));
            naddr  = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) naddr[1:0] = 2'($urandom_range(1, 3));
            nwdata = $urandom;
            if (p == 0) begin
              c_we[k] = nwe; c_addr[k] = naddr; c_wdata[k] = nwdata;
            end else begin
              a_we[k] = nwe; a_addr[k] = naddr; a_wdata[k] = nwdata;
            end
          end
          if ((p == 0) ? c_ack[k] : a_ack[k]) drop[k][p] = 1'b1;
        end
        c_req[k] = pend[k][0];
        a_req[k] = pend[k][1];

        // Arbitration decision when the arbiter can accept a new request this cycle
        if (!rst && n >= next_free[k] && (c_req[k] || a_req[k])) begin
          bit win;
          int idx;
          if (c_req[k] && a_req[k]) win = fixed_of(k) ? 1'b0 : !last_gnt[k];
          else win = a_req[k];
          last_gnt[k] = win;
          t_port[k]  = win;
          t_we[k]    = win ? a_we[k] : c_we[k];
          t_addr[k]  = win ? a_addr[k] : c_addr[k];
          t_wdata[k] = win ? a_wdata[k] : c_wdata[k];
          t_mis[k]   = (t_addr[k] % 4) != 0;
          idx        = int'(t_addr[k] / 4) % 16;
          t_issue[k] = n + 1;
          if (t_mis[k] || t_we[k]) begin
            t_ack[k]     = n + 1;
            next_free[k] = n + 3;
          end else begin
            t_ack[k]     = n + 2 + rl_of(k);
            next_free[k] = n + 4 + rl_of(k);
          end
          t_rdata[k] = t_mis[k] ? 32'h0 : ref_mem[k][idx];
          if (t_we[k] && !t_mis[k]) ref_mem[k][idx] = t_wdata[k];
          active[k] = 1'b1;
        end
      end

      #1;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("%0d:c_stall", k), 32'(c_stall[k]), 32'(c_req[k] && !c_ack[k]));
      end
      rst_prev = rst;
    end

    check("rr_ack_activity", 32'(n_acks[0] > 200), 32'h1);
    check("fp_ack_activity", 32'(n_acks[1] > 200), 32'h1);
    check("err_ack_activity", 32'(n_err_acks > 10), 32'h1);
    check("reset_activity", 32'(n_resets > 0), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
